// File: rtl/axis_snoop_gate.sv
// axis_snoop_gate: passive AXI-Stream tap that copies whole packets into a snoop FIFO without ever stalling the link
//   s_axis_aclk, s_axis_aresetn : clock, async active-low reset
//   snoop_*                     : passive copy of the monitored link (a beat is tvalid && tready)
//   enable, fifo_prog_full      : capture admission, sampled only at packet start
//   m_axis_*                    : single-slot registered master towards the snoop FIFO
//   pkt_count/drop_count/trunc_count : saturating forwarded / dropped / truncated packet counters
module axis_snoop_gate #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT_LEN = 1500,
  parameter logic [DATA_WIDTH-1:0] TERM_DATA = '0
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_aresetn,
  input  logic                  snoop_tvalid,
  input  logic                  snoop_tready,
  input  logic [DATA_WIDTH-1:0] snoop_tdata,
  input  logic                  snoop_tlast,
  input  logic                  enable,
  input  logic                  fifo_prog_full,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count,
  output logic [31:0]           trunc_count
);
  typedef enum logic [1:0] {IDLE, PASS, DROP, TERM} state_t;
  state_t state;
  logic [15:0] beat_cnt;
  logic tail_seen, tap_beat, slot_free, tail, cap;
  assign tap_beat = snoop_tvalid && snoop_tready;
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign tail = tap_beat && snoop_tlast;
  assign cap = beat_cnt + 16'd1 == 16'(MAX_PKT_LEN);
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn)
    if (!s_axis_aresetn) begin
      state <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      beat_cnt <= '0;
      tail_seen <= 1'b0;
      pkt_count <= '0;
      drop_count <= '0;
      trunc_count <= '0;
    end else begin
      // a load below overrides this drain
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      case (state)
        IDLE: if (tap_beat) begin
          if (fifo_prog_full || !enable) begin
            drop_count <= sat_inc(drop_count);
            state <= snoop_tlast ? IDLE : DROP;
          end else begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= snoop_tdata;
            m_axis_tlast <= snoop_tlast;
            beat_cnt <= 16'd1;
            if (snoop_tlast) pkt_count <= sat_inc(pkt_count);
            else state <= PASS;
          end
        end
        PASS: if (tap_beat) begin
          if (slot_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= snoop_tdata;
            m_axis_tlast <= snoop_tlast || cap;
            beat_cnt <= beat_cnt + 16'd1;
            if (snoop_tlast || cap) pkt_count <= sat_inc(pkt_count);
            if (!snoop_tlast && cap) trunc_count <= sat_inc(trunc_count);
            state <= snoop_tlast ? IDLE : cap ? DROP : PASS;
          end else begin
            // slot still occupied: this beat is lost, so the packet must be closed by a terminator
            trunc_count <= sat_inc(trunc_count);
            tail_seen <= snoop_tlast;
            state <= TERM;
          end
        end
        TERM: begin
          if (tail) tail_seen <= 1'b1;
          if (slot_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= TERM_DATA;
            m_axis_tlast <= 1'b1;
            pkt_count <= sat_inc(pkt_count);
            state <= (tail_seen || tail) ? IDLE : DROP;
          end
        end
        DROP: if (tail) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axis_snoop_gate.sv
// tb_axis_snoop_gate: directed scenarios plus random traffic checked against a packet-rule reference model
module tb_axis_snoop_gate;
  localparam int DW = 8;
  localparam int MAXL = 8;
  localparam logic [DW-1:0] TERM = 8'hEE;
  logic clk = 0, rst_n = 0;
  logic snoop_tvalid = 0, snoop_tready = 0, snoop_tlast = 0, enable = 1, fifo_prog_full = 0;
  logic [DW-1:0] snoop_tdata = 0;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [31:0] pkt_count, drop_count, trunc_count;
  int n_cmp = 0, n_bad = 0;
  logic e_valid, e_last;
  logic [DW-1:0] e_data;
  logic [31:0] e_pkt, e_drop, e_trunc;
  int fwd;
  bit in_pkt, skipping, owe_term, tail_pending;

  axis_snoop_gate #(.DATA_WIDTH(DW), .MAX_PKT_LEN(MAXL), .TERM_DATA(TERM)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tdata(snoop_tdata), .snoop_tlast(snoop_tlast),
    .enable(enable), .fifo_prog_full(fifo_prog_full),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    {e_valid, e_last, e_data} = '0;
    {e_pkt, e_drop, e_trunc} = '0;
    fwd = 0;
    {in_pkt, skipping, owe_term, tail_pending} = '0;
  endtask

  // one clock of packet-level rules: admit, forward, truncate, terminate, discard
  task automatic model_step();
    bit tap, free, ld, ld_l;
    logic [DW-1:0] ld_d;
    tap = snoop_tvalid && snoop_tready;
    free = !e_valid || m_axis_tready;
    ld = 0; ld_l = 0; ld_d = '0;
    if (owe_term) begin
      if (tap && snoop_tlast) tail_pending = 1;
      if (free) begin
        ld = 1; ld_d = TERM; ld_l = 1;
        e_pkt = sat(e_pkt);
        owe_term = 0;
        skipping = !tail_pending;
      end
    end else if (skipping) begin
      if (tap && snoop_tlast) skipping = 0;
    end else if (in_pkt) begin
      if (tap && free) begin
        fwd++;
        ld = 1; ld_d = snoop_tdata; ld_l = snoop_tlast || fwd == MAXL;
        if (ld_l) begin in_pkt = 0; e_pkt = sat(e_pkt); end
        if (!snoop_tlast && fwd == MAXL) begin e_trunc = sat(e_trunc); skipping = 1; end
      end else if (tap) begin
        e_trunc = sat(e_trunc);
        in_pkt = 0; owe_term = 1; tail_pending = snoop_tlast;
      end
    end else if (tap) begin
      if (fifo_prog_full || !enable) begin
        e_drop = sat(e_drop);
        skipping = !snoop_tlast;
      end else begin
        fwd = 1;
        ld = 1; ld_d = snoop_tdata; ld_l = snoop_tlast;
        if (snoop_tlast) e_pkt = sat(e_pkt); else in_pkt = 1;
      end
    end
    if (ld) begin e_valid = 1; e_data = ld_d; e_last = ld_l; end
    else if (m_axis_tready) e_valid = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("tvalid", 32'(m_axis_tvalid), 32'(e_valid));
    check("tdata", 32'(m_axis_tdata), 32'(e_data));
    check("tlast", 32'(m_axis_tlast), 32'(e_last));
    check("pkt_count", pkt_count, e_pkt);
    check("drop_count", drop_count, e_drop);
    check("trunc_count", trunc_count, e_trunc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata", 32'(m_axis_tdata), 0);
    check("rst_tlast", 32'(m_axis_tlast), 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_trunc", trunc_count, 0);
    model_reset();
    {snoop_tvalid, snoop_tready, snoop_tlast, fifo_prog_full} = '0;
    snoop_tdata = '0; enable = 1; m_axis_tready = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    snoop_tvalid = 1; snoop_tready = 1; snoop_tdata = d; snoop_tlast = l;
    cycle();
    snoop_tvalid = 0; snoop_tlast = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    do_reset();
    // four-beat packet straight through
    for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), i == 4);
    idle(2);
    check("basic_pkt", pkt_count, 1);
    // admission refused at start, whole packet dropped even after prog_full clears
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      fifo_prog_full = i < 3;
      send(8'(8'h20 + i), i == 10);
    end
    fifo_prog_full = 0;
    idle(1);
    check("drop_drop", drop_count, 1);
    check("drop_pkt", pkt_count, 0);
    send(8'h2F, 1);
    idle(1);
    check("drop_then_idle", pkt_count, 1);
    // long packet cut at MAXL beats
    do_reset();
    for (int i = 1; i <= 12; i++) send(8'(8'h40 + i), i == 12);
    idle(2);
    check("trunc_trunc", trunc_count, 1);
    check("trunc_pkt", pkt_count, 1);
    // output stall overflows the slot: terminator closes the packet
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      m_axis_tready = i < 3;
      send(8'(8'h30 + i), i == 6);
    end
    idle(2);
    m_axis_tready = 1;
    idle(3);
    check("ovf_trunc", trunc_count, 1);
    check("ovf_pkt", pkt_count, 1);
    // back-to-back packets without a gap
    do_reset();
    for (int i = 1; i <= 3; i++) send(8'(8'h50 + i), i == 3);
    for (int i = 1; i <= 3; i++) send(8'(8'h60 + i), i == 3);
    idle(2);
    check("b2b_pkt", pkt_count, 2);
    // reset mid-packet while the slot holds a beat
    send(8'h71, 0);
    send(8'h72, 0);
    check("pre_rst_valid", 32'(m_axis_tvalid), 1);
    do_reset();
    for (int i = 1; i <= 3; i++) send(8'(8'h80 + i), i == 3);
    idle(2);
    check("post_rst_pkt", pkt_count, 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      snoop_tvalid = $urandom_range(0, 3) != 0;
      snoop_tready = $urandom_range(0, 3) != 0;
      snoop_tdata = 8'($urandom);
      snoop_tlast = $urandom_range(0, 5) == 0;
      enable = $urandom_range(0, 7) != 0;
      fifo_prog_full = $urandom_range(0, 7) == 0;
      m_axis_tready = $urandom_range(0, 3) != 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
